// File: rtl/bit_scan_iter.sv
// Set-bit iterator: captures an N-bit vector and emits the index of each set bit,
// one beat per cycle, in LSB-first or MSB-first order chosen per vector.
module bit_scan_iter #(
  parameter  int unsigned N = 32,
  parameter  int unsigned B = 4,
  localparam int unsigned M = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_data,
  input  logic         i_msb_first,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [M-1:0] o_index,
  output logic         o_last,
  output logic         o_none
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("bit_scan_iter: N must be a power of 2 and at least 2");
  end
  if (B != 2 && B != 4) begin : g_bad_b
    $error("bit_scan_iter: B must be 2 or 4");
  end

  // Detector tree geometry: L levels of B-way nodes over a zero-padded vector.
  localparam int unsigned LB = (B == 4) ? 2 : 1;
  localparam int unsigned L  = (M + LB - 1) / LB;
  localparam int unsigned IW = L * LB;
  localparam int unsigned NP = 1 << IW;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dir_q, dir_d;
  logic           none_q, none_d;
  logic [N-1:0]   data_rev;
  logic [M-1:0]   p;
  logic           fire_out;
  logic           capture;

  // Lowest set bit via a B-ary tree; each node forwards its lowest valid child.
  function automatic logic [M-1:0] lowest_set(input logic [N-1:0] vec);
    logic [NP-1:0] pad;
    logic          v  [NP];
    logic [IW-1:0] ix [NP];
    logic          nv;
    logic [IW-1:0] nix;
    pad = NP'(vec);
    for (int unsigned i = 0; i < NP; i++) begin
      v[i]  = pad[i];
      ix[i] = '0;
    end
    for (int unsigned l = 0; l < L; l++) begin
      for (int unsigned j = 0; j < (NP >> ((l + 1) * LB)); j++) begin
        nv  = 1'b0;
        nix = '0;
        for (int k = int'(B) - 1; k >= 0; k--) begin
          if (v[j * B + k]) begin
            nv  = 1'b1;
            nix = ix[j * B + k] | (IW'(k) << (l * LB));
          end
        end
        v[j]  = nv;
        ix[j] = nix;
      end
    end
    return M'(ix[0]);
  endfunction

  always_comb begin
    data_rev = '0;
    for (int unsigned i = 0; i < N; i++) begin
      data_rev[i] = i_data[N - 1 - i];
    end
  end

  assign p        = lowest_set(rem_q);
  assign o_valid  = (state_q == S_SCAN);
  assign o_index  = none_q ? '0 : (dir_q ? ~p : p);
  assign o_last   = none_q || ((rem_q & (rem_q - N'(1))) == '0);
  assign o_none   = none_q;
  assign fire_out = o_valid && i_ready;
  assign o_ready  = (state_q == S_IDLE) || (fire_out && o_last);
  assign capture  = i_valid && o_ready;

  // Next state: retire the current bit on a beat; a capture overrides everything.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    none_d  = none_q;
    if (fire_out) begin
      rem_d = rem_q & ~(N'(1) << p);
      if (o_last) begin
        state_d = S_IDLE;
        dir_d   = 1'b0;
        none_d  = 1'b0;
      end
    end
    if (capture) begin
      rem_d   = i_msb_first ? data_rev : i_data;
      dir_d   = i_msb_first;
      none_d  = (i_data == '0);
      state_d = S_SCAN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      none_q  <= none_d;
    end
  end

endmodule
